// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler: per-frame sequencer and plot-port arbiter for
// four drawing clients, with watchdog abort and dropped-tick counting.
module frame_draw_scheduler #(
  parameter int TO_W = 20,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 20'd307200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [3:0]  client_mask,
  input  logic [35:0] client_x,
  input  logic [31:0] client_y,
  input  logic [47:0] client_color,
  input  logic [3:0]  client_we,
  input  logic [3:0]  client_done,
  output logic [3:0]  client_enable,
  output logic [8:0]  plot_x,
  output logic [7:0]  plot_y,
  output logic [11:0] plot_color,
  output logic        plot_we,
  output logic        frame_busy,
  output logic        frame_done,
  output logic [3:0]  timeout_status,
  output logic [7:0]  overrun_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_WAIT,
    S_ADVANCE,
    S_DONE
  } state_t;

  localparam logic [TO_W-1:0] WD_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0] WD_LAST = TIMEOUT_CYCLES - WD_ONE;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      mask_q, mask_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [3:0]      to_q, to_d;
  logic [7:0]      ovr_q, ovr_d;
  logic [8:0]      px_q, px_d;
  logic [7:0]      py_q, py_d;
  logic [11:0]     pc_q, pc_d;
  logic            pwe_q, pwe_d;

  logic [8:0]      sel_x;
  logic [7:0]      sel_y;
  logic [11:0]     sel_c;
  logic            sel_we;
  logic            sel_done;

  // Owner-only view of the client buses; everyone else is ignored.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_c = '0;
    for (int i = 0; i < 4; i++) begin
      if (idx_q == 2'(i)) begin
        sel_x = client_x[9*i +: 9];
        sel_y = client_y[8*i +: 8];
        sel_c = client_color[12*i +: 12];
      end
    end
    sel_we   = client_we[idx_q];
    sel_done = client_done[idx_q];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    wd_d    = wd_q;
    to_d    = to_q;
    ovr_d   = ovr_q;
    px_d    = px_q;
    py_d    = py_q;
    pc_d    = pc_q;
    pwe_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          mask_d  = client_mask;
          to_d    = '0;
          idx_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = mask_q[idx_q] ? S_START : S_ADVANCE;
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        px_d  = sel_x;
        py_d  = sel_y;
        pc_d  = sel_c;
        pwe_d = sel_we;
        if (sel_done) begin
          state_d = S_ADVANCE;
        end else if (wd_q == WD_LAST) begin
          to_d[idx_q] = 1'b1;
          state_d     = S_ADVANCE;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      S_ADVANCE: begin
        if (idx_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // DONE still counts as busy, so a tick there is dropped too.
    if (frame_tick && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      wd_q    <= '0;
      to_q    <= '0;
      ovr_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pc_q    <= '0;
      pwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      ovr_q   <= ovr_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pc_q    <= pc_d;
      pwe_q   <= pwe_d;
    end
  end

  assign client_enable  = (state_q == S_START) ? (4'b0001 << idx_q) : 4'b0000;
  assign frame_busy     = (state_q != S_IDLE);
  assign frame_done     = (state_q == S_DONE);
  assign timeout_status = to_q;
  assign overrun_count  = ovr_q;
  assign plot_x         = px_q;
  assign plot_y         = py_q;
  assign plot_color     = pc_q;
  assign plot_we        = pwe_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb_frame_draw_scheduler: directed scenario tasks for the frame
// sequencer, watchdog set to 16 cycles.
module tb_frame_draw_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [3:0]  client_mask;
  logic [35:0] client_x;
  logic [31:0] client_y;
  logic [47:0] client_color;
  logic [3:0]  client_we;
  logic [3:0]  client_done;
  logic [3:0]  client_enable;
  logic [8:0]  plot_x;
  logic [7:0]  plot_y;
  logic [11:0] plot_color;
  logic        plot_we;
  logic        frame_busy;
  logic        frame_done;
  logic [3:0]  timeout_status;
  logic [7:0]  overrun_count;

  int checks = 0;
  int passed = 0;

  int en_c[4];
  int done_c;
  int pulses;
  int multi;
  int we_seen;

  frame_draw_scheduler #(
    .TO_W(20),
    .TIMEOUT_CYCLES(20'd16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .client_mask(client_mask),
    .client_x(client_x),
    .client_y(client_y),
    .client_color(client_color),
    .client_we(client_we),
    .client_done(client_done),
    .client_enable(client_enable),
    .plot_x(plot_x),
    .plot_y(plot_y),
    .plot_color(plot_color),
    .plot_we(plot_we),
    .frame_busy(frame_busy),
    .frame_done(frame_done),
    .timeout_status(timeout_status),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts a frame, answers each enable with done after dly cycles
  // (0 = never), and records the cycle of every event after the tick.
  task automatic run_frame(input logic [3:0] m,
                           input int d0, input int d1,
                           input int d2, input int d3);
    int dly[4];
    int done_at;
    int own;
    int n;
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    for (int i = 0; i < 4; i++) en_c[i] = -1;
    done_c = -1; pulses = 0; multi = 0; we_seen = 0;
    done_at = -1; own = 0;
    client_mask = m;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    client_mask = ~m;
    n = 1;
    while (n < 200 && done_c < 0) begin
      if (client_enable != 4'b0000) begin
        pulses++;
        if ($countones(client_enable) != 1) multi++;
        for (int i = 0; i < 4; i++) begin
          if (client_enable[i]) begin
            en_c[i] = n;
            own = i;
            done_at = (dly[i] > 0) ? n + dly[i] : -1;
          end
        end
      end
      if (plot_we) we_seen++;
      if (frame_done) done_c = n;
      client_done = (n == done_at) ? (4'b0001 << own) : 4'b0000;
      tick();
      n++;
    end
    client_done = 4'b0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({client_enable, plot_x, plot_y, plot_color, plot_we, frame_busy,
         frame_done, timeout_status, overrun_count} !== '0)
      $display("FAIL reset_outputs got en=%b x=%0d y=%0d c=%h we=%b busy=%b done=%b to=%b ovr=%0d want all 0",
               client_enable, plot_x, plot_y, plot_color, plot_we,
               frame_busy, frame_done, timeout_status, overrun_count);
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_all_masked();
    run_frame(4'b0000, 1, 1, 1, 1);
    checks++;
    if (pulses !== 0) $display("FAIL masked_enables got %0d want 0", pulses);
    else passed++;
    checks++;
    if (done_c !== 9) $display("FAIL masked_done_cycle got %0d want 9", done_c);
    else passed++;
    checks++;
    if (we_seen !== 0) $display("FAIL masked_plot_we got %0d want 0", we_seen);
    else passed++;
    checks++;
    if (frame_busy !== 1'b0) $display("FAIL masked_busy_after got %b want 0", frame_busy);
    else passed++;
  endtask

  task automatic test_all_clients();
    int want[4];
    want[0] = 2; want[1] = 10; want[2] = 18; want[3] = 26;
    run_frame(4'b1111, 5, 5, 5, 5);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (en_c[i] !== want[i])
        $display("FAIL order_enable%0d got cycle %0d want %0d", i, en_c[i], want[i]);
      else passed++;
    end
    checks++;
    if (pulses !== 4) $display("FAIL order_pulses got %0d want 4", pulses);
    else passed++;
    checks++;
    if (multi !== 0) $display("FAIL order_onehot got %0d multi-hot want 0", multi);
    else passed++;
    checks++;
    if (done_c !== 33) $display("FAIL order_done_cycle got %0d want 33", done_c);
    else passed++;
    checks++;
    if (frame_busy !== 1'b0) $display("FAIL order_busy_after got %b want 0", frame_busy);
    else passed++;
  endtask

  task automatic test_ownership();
    int n;
    client_mask = 4'b0100;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    n = 0;
    while (!client_enable[2] && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 5) $display("FAIL own_enable_wait got %0d want 5", n);
    else passed++;
    client_done = 4'b0100;
    tick();
    client_done = 4'b0000;
    client_x = {9'd0, 9'd150, 9'd0, 9'd7};
    client_y = {8'd0, 8'd30, 8'd0, 8'd9};
    client_color = {12'h000, 12'hF00, 12'h000, 12'h0AB};
    client_we = 4'b0101;
    tick();
    checks++;
    if (plot_x !== 9'd150) $display("FAIL own_plot_x got %0d want 150", plot_x);
    else passed++;
    checks++;
    if (plot_y !== 8'd30) $display("FAIL own_plot_y got %0d want 30", plot_y);
    else passed++;
    checks++;
    if (plot_color !== 12'hF00) $display("FAIL own_plot_color got %h want f00", plot_color);
    else passed++;
    checks++;
    if (plot_we !== 1'b1) $display("FAIL own_plot_we got %b want 1", plot_we);
    else passed++;
    client_we = 4'b0001;
    client_done = 4'b0001;
    tick();
    checks++;
    if (plot_we !== 1'b0) $display("FAIL nonowner_we got %b want 0", plot_we);
    else passed++;
    client_x[26:18] = 9'd151;
    client_we = 4'b0100;
    client_done = 4'b0100;
    tick();
    checks++;
    if ({plot_we, plot_x} !== {1'b1, 9'd151})
      $display("FAIL we_with_done got we=%b x=%0d want we=1 x=151", plot_we, plot_x);
    else passed++;
    client_we = 4'b0000;
    client_done = 4'b0000;
    n = 0;
    while (!frame_done && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 3) $display("FAIL own_done_wait got %0d want 3", n);
    else passed++;
    checks++;
    if ({plot_we, plot_x} !== {1'b0, 9'd151})
      $display("FAIL plot_hold got we=%b x=%0d want we=0 x=151", plot_we, plot_x);
    else passed++;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    run_frame(4'b0110, 0, 0, 3, 0);
    checks++;
    if (en_c[1] !== 4) $display("FAIL to_enable1 got %0d want 4", en_c[1]);
    else passed++;
    checks++;
    if (en_c[2] !== 23) $display("FAIL to_enable2 got %0d want 23", en_c[2]);
    else passed++;
    checks++;
    if (timeout_status !== 4'b0010) $display("FAIL to_status got %b want 0010", timeout_status);
    else passed++;
    client_mask = 4'b0000;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    checks++;
    if (timeout_status !== 4'b0000) $display("FAIL to_status_clear got %b want 0000", timeout_status);
    else passed++;
    n = 0;
    while (frame_busy && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic test_overrun();
    int n;
    client_mask = 4'b0000;
    frame_tick = 1'b1;
    tick();
    n = 1;
    while (n < 12) begin
      frame_tick = (n == 3 || n == 5 || n == 9);
      if (n == 9) begin
        checks++;
        if (frame_done !== 1'b1) $display("FAIL ovr_done_cycle got %b want 1", frame_done);
        else passed++;
      end
      tick();
      n++;
    end
    frame_tick = 1'b0;
    checks++;
    if (overrun_count !== 8'd3) $display("FAIL ovr_count3 got %0d want 3", overrun_count);
    else passed++;
    frame_tick = 1'b1;
    repeat (320) tick();
    frame_tick = 1'b0;
    n = 0;
    while (frame_busy && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (overrun_count !== 8'd255) $display("FAIL ovr_saturate got %0d want 255", overrun_count);
    else passed++;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    checks++;
    if ({frame_busy, overrun_count} !== {1'b1, 8'd255})
      $display("FAIL ovr_idle_accept got busy=%b ovr=%0d want busy=1 ovr=255", frame_busy, overrun_count);
    else passed++;
    n = 1;
    while (!frame_done && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 9) $display("FAIL ovr_frame_len got %0d want 9", n);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    client_mask = 4'b1000;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    n = 0;
    while (!client_enable[3] && n < 30) begin
      tick();
      n++;
    end
    tick();
    client_x[35:27] = 9'd300;
    client_y[31:24] = 8'd200;
    client_color[47:36] = 12'hABC;
    client_we = 4'b1000;
    tick();
    checks++;
    if ({plot_we, plot_x} !== {1'b1, 9'd300})
      $display("FAIL rst_pre_write got we=%b x=%0d want we=1 x=300", plot_we, plot_x);
    else passed++;
    reset = 1'b1;
    client_we = 4'b0000;
    tick();
    reset = 1'b0;
    checks++;
    if ({client_enable, plot_x, plot_y, plot_color, plot_we, frame_busy,
         frame_done, timeout_status, overrun_count} !== '0)
      $display("FAIL rst_mid_outputs got en=%b x=%0d y=%0d c=%h we=%b busy=%b done=%b to=%b ovr=%0d want all 0",
               client_enable, plot_x, plot_y, plot_color, plot_we,
               frame_busy, frame_done, timeout_status, overrun_count);
    else passed++;
    bad = 0;
    repeat (20) begin
      tick();
      if (client_enable != 4'b0000 || frame_done || frame_busy) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL rst_quiet got %0d bad cycles want 0", bad);
    else passed++;
    run_frame(4'b0001, 2, 0, 0, 0);
    checks++;
    if (en_c[0] !== 2) $display("FAIL rst_clean_enable0 got %0d want 2", en_c[0]);
    else passed++;
    checks++;
    if (done_c !== 12) $display("FAIL rst_clean_done got %0d want 12", done_c);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    client_mask = 4'b0000;
    client_x = '0;
    client_y = '0;
    client_color = '0;
    client_we = 4'b0000;
    client_done = 4'b0000;
    test_reset();
    test_all_masked();
    test_all_clients();
    test_ownership();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
